// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: angle constants (LSB = 2^-14 rad), atan table and FSM states.
// Used by both the vectoring and the rotation blocks.
package cordic_pkg;

    localparam int ANGLE_PI   = 51472;
    localparam int ANGLE_PI_2 = 25736;
    localparam int ATAN_DEPTH = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } cordic_state_e;

    // atan(2^-i) in angle LSBs, rounded to nearest.
    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        logic [15:0] v;
        v = '0;
        case (idx)
            4'd0:  v = 16'd12868;
            4'd1:  v = 16'd7596;
            4'd2:  v = 16'd4014;
            4'd3:  v = 16'd2037;
            4'd4:  v = 16'd1023;
            4'd5:  v = 16'd512;
            4'd6:  v = 16'd256;
            4'd7:  v = 16'd128;
            4'd8:  v = 16'd64;
            4'd9:  v = 16'd32;
            4'd10: v = 16'd16;
            4'd11: v = 16'd8;
            4'd12: v = 16'd4;
            4'd13: v = 16'd2;
            4'd14: v = 16'd1;
            4'd15: v = 16'd1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table lookup: micro-rotation index to atan(2^-i) in angle LSBs.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [3:0]  i_step,
    output logic [15:0] o_atan
);

    always_comb begin
        o_atan = atan_lut(i_step);
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: returns atan2(y, x) and the K-scaled magnitude of (x, y),
// one micro-rotation per clock, with valid/ready handshakes on input and output.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int STEPS = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BITS:0]   x_in,
    input  logic signed [BITS:0]   y_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BITS:0]   angle,
    output logic        [BITS+1:0] magnitude
);

    localparam int XWidth = BITS + 3;
    localparam int ZWidth = BITS + 2;
    localparam logic [4:0] LastStep = 5'(STEPS);

    cordic_state_e r_state, w_state_next;

    logic        [4:0]        r_step;
    logic signed [XWidth-1:0] r_x, r_y;
    logic signed [ZWidth-1:0] r_z;
    logic                     r_zero;
    logic signed [BITS:0]     r_angle;
    logic        [BITS+1:0]   r_mag;

    logic        [15:0]       w_atan;
    logic signed [ZWidth-1:0] w_atan_ext;
    logic signed [XWidth-1:0] w_x_ext, w_y_ext;
    logic signed [XWidth-1:0] w_x_sh, w_y_sh;
    logic signed [XWidth-1:0] w_x_pre, w_y_pre;
    logic signed [ZWidth-1:0] w_z_pre;
    logic signed [BITS:0]     w_angle_clamped;

    cordic_atan_rom u_atan_rom (
        .i_step (r_step[3:0]),
        .o_atan (w_atan)
    );

    always_comb begin
        w_atan_ext = ZWidth'(w_atan);
        w_x_ext    = {{2{x_in[BITS]}}, x_in};
        w_y_ext    = {{2{y_in[BITS]}}, y_in};
        w_x_sh     = r_x >>> r_step;
        w_y_sh     = r_y >>> r_step;
    end

    // Fold the left half-plane onto the right so the iterations only need to cover +-pi/2.
    always_comb begin
        w_x_pre = w_x_ext;
        w_y_pre = w_y_ext;
        w_z_pre = '0;
        if (x_in[BITS]) begin
            if (!y_in[BITS]) begin
                w_x_pre = w_y_ext;
                w_y_pre = -w_x_ext;
                w_z_pre = ZWidth'(ANGLE_PI_2);
            end else begin
                w_x_pre = -w_y_ext;
                w_y_pre = w_x_ext;
                w_z_pre = -ZWidth'(ANGLE_PI_2);
            end
        end
    end

    always_comb begin
        w_angle_clamped = r_z[BITS:0];
        if (r_z > ZWidth'(ANGLE_PI)) begin
            w_angle_clamped = (BITS+1)'(ANGLE_PI);
        end else if (r_z < -ZWidth'(ANGLE_PI)) begin
            w_angle_clamped = -(BITS+1)'(ANGLE_PI);
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = StIter;
                end
            end
            StIter: begin
                if (r_step == LastStep) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_step  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_zero  <= 1'b0;
            r_angle <= '0;
            r_mag   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && in_valid) begin
                r_x    <= w_x_pre;
                r_y    <= w_y_pre;
                r_z    <= w_z_pre;
                r_step <= '0;
                r_zero <= (x_in == '0) && (y_in == '0);
            end else if (r_state == StIter) begin
                // The cycle after the last micro-rotation registers the results.
                if (r_step == LastStep) begin
                    r_angle <= r_zero ? '0 : w_angle_clamped;
                    r_mag   <= r_zero ? '0 : r_x[BITS+1:0];
                end else begin
                    r_step <= r_step + 5'd1;
                    if (!r_y[XWidth-1]) begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + w_atan_ext;
                    end else begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - w_atan_ext;
                    end
                end
            end
        end
    end

    assign angle     = r_angle;
    assign magnitude = r_mag;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: real-arithmetic atan2/hypot reference, randomized
// vectors and back-pressure, plus latency, hold-stability and mid-operation reset scenarios.
module tb_cordic_vectoring;

    localparam int BITS  = 16;
    localparam int STEPS = 15;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [BITS:0]   x_in;
    logic signed [BITS:0]   y_in;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [BITS:0]   angle;
    logic        [BITS+1:0] magnitude;

    typedef struct {
        longint ang;
        longint mag;
        longint tol_a;
        longint tol_m;
        longint acc;
    } exp_t;

    exp_t   sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    int     or_mode = 1;  // 0: out_ready low, 1: high, 2: random
    bit     prev_ov = 1'b0;

    cordic_vectoring #(
        .BITS  (BITS),
        .STEPS (STEPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle     (angle),
        .magnitude (magnitude)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (or_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
        else              out_ready = (or_mode == 1);
    end

    task automatic check(input string name, input longint got, input longint exp,
                         input longint tol);
        longint d;
        d = got - exp;
        if (d < 0) d = -d;
        n_tests++;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d",
                     name, got, exp, tol, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Ideal atan2 and K*hypot, K taken over the STEPS micro-rotations.
    function automatic exp_t model(input int x, input int y);
        exp_t e;
        real  a, k, p;
        k = 1.0;
        p = 1.0;
        for (int i = 0; i < STEPS; i++) begin
            k = k * $sqrt(1.0 + p);
            p = p * 0.25;
        end
        if (x == 0 && y == 0) begin
            e.ang = 0;
            e.mag = 0;
        end else begin
            a     = $atan2(real'(y), real'(x)) * 16384.0;
            e.ang = longint'(a);
            if (e.ang > 51472)  e.ang = 51472;
            if (e.ang < -51472) e.ang = -51472;
            e.mag = longint'(k * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
        end
        e.tol_a = 0;
        e.tol_m = 0;
        e.acc   = 0;
        return e;
    endfunction

    task automatic send(input int x, input int y, input longint tol_a, input longint tol_m);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        x_in     = x[BITS:0];
        y_in     = y[BITS:0];
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            flag("accept_timeout");
            in_valid = 1'b0;
        end else begin
            e       = model(x, y);
            e.tol_a = tol_a;
            e.tol_m = tol_m;
            e.acc   = cyc + 1;
            sb_q.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            flag("drain_timeout");
            sb_q.delete();
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb_q.size() == 0) flag("unexpected_out_valid");
                else check("latency", cyc - sb_q[0].acc, STEPS + 1, 0);
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("angle", angle, e.ang, e.tol_a);
                check("magnitude", magnitude, e.mag, e.tol_m);
            end
            prev_ov = out_valid;
        end
    end

    int     dx[7] = '{16384, 0, 0, -16384, -11585, 0, -65536};
    int     dy[7] = '{0, 16384, -16384, 0, -11585, 0, -65536};
    int     dta[7] = '{STEPS, STEPS, STEPS, STEPS, STEPS, 0, STEPS};
    int     dtm[7] = '{8, 8, 8, 8, 8, 0, 16};

    initial begin
        longint hold_a, hold_m;
        int     bad, waited, rx, ry;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x_in     = '0;
        y_in     = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1, 0);
        check("reset_out_valid", out_valid, 0, 0);
        check("reset_angle", angle, 0, 0);
        check("reset_magnitude", magnitude, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send(dx[i], dy[i], dta[i], dtm[i]);
            wait_idle();
        end

        // Back-pressure: result held for 20 cycles while in_valid pulses are ignored.
        or_mode = 0;
        @(posedge clk);
        send(12000, -7000, 32, 32);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) begin
            flag("hold_out_valid_timeout");
        end else begin
            hold_a = angle;
            hold_m = magnitude;
            bad    = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                in_valid = (i % 2 == 0);
                x_in     = BITS'($urandom);
                y_in     = BITS'($urandom);
                @(negedge clk);
                if (angle != hold_a || magnitude != hold_m || in_ready || !out_valid) bad++;
            end
            check("hold_stable", bad, 0, 0);
            in_valid = 1'b0;
            or_mode  = 1;
            @(posedge clk);
            @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            check("after_xfer_out_valid", out_valid, 0, 0);
            check("after_xfer_in_ready", in_ready, 1, 0);
        end
        wait_idle();

        // Reset in the middle of the iterations.
        send(20000, 9000, 32, 32);
        wait_idle();
        send(-15000, 12000, 32, 32);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midreset_angle", angle, 0, 0);
        check("midreset_magnitude", magnitude, 0, 0);
        check("midreset_out_valid", out_valid, 0, 0);
        check("midreset_in_ready", in_ready, 1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad   = 0;
        repeat (STEPS + 5) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("no_output_after_reset", bad, 0, 0);
        send(-15000, 12000, 32, 32);
        wait_idle();

        // Randomized vectors with random back-pressure.
        or_mode = 2;
        for (int i = 0; i < 40; i++) begin
            do begin
                rx = int'($urandom_range(0, 131071)) - 65536;
                ry = int'($urandom_range(0, 131071)) - 65536;
            end while ((rx < 16384 && rx > -16384) && (ry < 16384 && ry > -16384));
            send(rx, ry, 32, 32);
        end
        wait_idle();
        or_mode = 1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
